// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered or first-word-fall-through read, status flags and occupancy count.
// Define UART_FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow flags; otherwise those ports are tied to 0.
module uart_sync_fifo #(
    parameter int DATA_WIDTH    = 8,
    parameter int FIFO_DEPTH    = 16,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 2,
    parameter int FWFT          = 0,
    localparam int CW           = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  wr_ok, rd_ok;

    // Flags decode the registered count only, so they never depend on this cycle's requests.
    assign full         = (count_q == CW'(FIFO_DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CW'(AFULL_THRESH));
    assign almost_empty = (count_q <= CW'(AEMPTY_THRESH));
    assign count        = count_q;

    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Compare-and-clear wrap keeps non-power-of-2 depths exact.
            if (wr_ok) wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            if (rd_ok) rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_ok && !flush) mem_q[wr_ptr_q] <= wr_data;
    end

    generate
        if (FWFT == 0) begin : g_reg_read
            logic [DATA_WIDTH-1:0] rd_data_q;
            logic                  rd_valid_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else if (flush) begin
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_ok;
                    if (rd_ok) rd_data_q <= mem_q[rd_ptr_q];
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end else begin : g_fwft_read
            // Gate on empty so the uninitialised array never reaches the port.
            assign rd_data  = empty ? '0 : mem_q[rd_ptr_q];
            assign rd_valid = !empty && !flush;
        end
    endgenerate

`ifdef UART_FIFO_ERR_FLAGS_EN
    logic overflow_q, underflow_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (flush) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_en && full)  overflow_q  <= 1'b1;
            if (rd_en && empty) underflow_q <= 1'b1;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_uart_sync_fifo.sv
// Directed bench for uart_sync_fifo: a registered-read and an FWFT instance (depth 5) share one stimulus stream.
module tb_uart_sync_fifo;

    localparam int DW = 8;
    localparam int CW = 3;

`ifdef UART_FIFO_ERR_FLAGS_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic          flush = 1'b0;

    logic [DW-1:0] rd_data0, rd_data1;
    logic          rd_valid0, rd_valid1;
    logic          full0, full1, empty0, empty1;
    logic          afull0, afull1, aempty0, aempty1;
    logic [CW-1:0] count0, count1;
    logic          ovf0, ovf1, udf0, udf1;

    int checks = 0;
    int failures = 0;

    uart_sync_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(5), .AFULL_THRESH(4), .AEMPTY_THRESH(1), .FWFT(0)) u_dut0 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .flush(flush),
        .rd_data(rd_data0), .rd_valid(rd_valid0), .full(full0), .empty(empty0),
        .almost_full(afull0), .almost_empty(aempty0), .count(count0),
        .overflow(ovf0), .underflow(udf0)
    );

    uart_sync_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(5), .AFULL_THRESH(4), .AEMPTY_THRESH(1), .FWFT(1)) u_dut1 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .flush(flush),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .full(full1), .empty(empty1),
        .almost_full(afull1), .almost_empty(aempty1), .count(count1),
        .overflow(ovf1), .underflow(udf1)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge: outputs settled, inputs safe to change.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        wr_en = 1'b1; wr_data = d; rd_en = 1'b0;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [DW-1:0] d);
        rd_en = 1'b1; wr_en = 1'b0;
        tick();
        rd_en = 1'b0;
        check_eq({tag, "_valid"}, 32'(rd_valid0), 32'd1);
        check_eq({tag, "_data"}, 32'(rd_data0), 32'(d));
    endtask

    initial begin
        // Reset state
        #3;
        check_eq("rst_count", 32'(count0), 32'd0);
        check_eq("rst_empty", 32'(empty0), 32'd1);
        check_eq("rst_full", 32'(full0), 32'd0);
        check_eq("rst_aempty", 32'(aempty0), 32'd1);
        check_eq("rst_afull", 32'(afull0), 32'd0);
        check_eq("rst_rd_valid", 32'(rd_valid0), 32'd0);
        check_eq("rst_rd_data", 32'(rd_data0), 32'd0);
        check_eq("rst_ovf", 32'(ovf0), 32'd0);
        check_eq("rst_udf", 32'(udf0), 32'd0);
        check_eq("rst_fwft_valid", 32'(rd_valid1), 32'd0);
        check_eq("rst_fwft_data", 32'(rd_data1), 32'd0);
        tick();
        tick();
        reset = 1'b0;

        // Fill 0x11..0x15, then drain in order
        for (int i = 0; i < 5; i++) begin
            push(DW'(8'h11 + i));
            if (i == 0) check_eq("fill_not_empty", 32'(empty0), 32'd0);
        end
        check_eq("fill_count", 32'(count0), 32'd5);
        check_eq("fill_full", 32'(full0), 32'd1);
        check_eq("fill_afull", 32'(afull0), 32'd1);
        for (int i = 0; i < 5; i++) pop_expect("drain", DW'(8'h11 + i));
        tick();
        check_eq("drain_pulse_end", 32'(rd_valid0), 32'd0);
        check_eq("drain_hold", 32'(rd_data0), 32'h15);
        check_eq("drain_empty", 32'(empty0), 32'd1);

        // Read while empty: rejected
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check_eq("udf_count", 32'(count0), 32'd0);
        check_eq("udf_no_valid", 32'(rd_valid0), 32'd0);
        check_eq("udf_flag", 32'(udf0), 32'(ERR_ON));

        // Simultaneous write+read while empty: write only, no bypass
        wr_en = 1'b1; wr_data = 8'h5A; rd_en = 1'b1;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        check_eq("empty_wr_rd_count", 32'(count0), 32'd1);
        check_eq("empty_wr_rd_no_valid", 32'(rd_valid0), 32'd0);
        pop_expect("empty_wr_rd_pop", 8'h5A);

        // Wrap: prime 3, then 12 simultaneous write/read cycles, then drain
        for (int i = 0; i < 3; i++) push(DW'(8'hA0 + i));
        for (int i = 0; i < 12; i++) begin
            wr_en = 1'b1; wr_data = DW'(8'hA3 + i); rd_en = 1'b1;
            tick();
            check_eq("wrap_data", 32'(rd_data0), 32'(8'hA0 + i));
            check_eq("wrap_count", 32'(count0), 32'd3);
        end
        wr_en = 1'b0; rd_en = 1'b0;
        pop_expect("wrap_tail0", 8'hAC);
        pop_expect("wrap_tail1", 8'hAD);
        pop_expect("wrap_tail2", 8'hAE);

        // Fill to full with flag checks, then write+read at full
        for (int k = 1; k <= 5; k++) begin
            push(DW'(8'h20 + k));
            check_eq("lvl_count", 32'(count0), 32'(k));
            check_eq("lvl_full", 32'(full0), 32'(k == 5));
            check_eq("lvl_afull", 32'(afull0), 32'(k >= 4));
            check_eq("lvl_aempty", 32'(aempty0), 32'(k <= 1));
        end
        wr_en = 1'b1; wr_data = 8'hAA; rd_en = 1'b1;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        check_eq("full_wr_rd_count", 32'(count0), 32'd4);
        check_eq("full_wr_rd_data", 32'(rd_data0), 32'h21);
        check_eq("full_wr_rd_ovf", 32'(ovf0), 32'(ERR_ON));
        for (int i = 0; i < 4; i++) pop_expect("full_tail", DW'(8'h22 + i));
        check_eq("full_tail_empty", 32'(empty0), 32'd1);

        // FWFT: word shows before any rd_en
        check_eq("fwft_pre_valid", 32'(rd_valid1), 32'd0);
        push(8'h3C);
        check_eq("fwft_valid", 32'(rd_valid1), 32'd1);
        check_eq("fwft_data", 32'(rd_data1), 32'h3C);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check_eq("fwft_pop_empty", 32'(empty1), 32'd1);
        check_eq("fwft_pop_valid", 32'(rd_valid1), 32'd0);

        // Flush beats a concurrent write and clears sticky flags
        for (int i = 0; i < 3; i++) push(DW'(8'h31 + i));
        check_eq("pre_flush_count", 32'(count0), 32'd3);
        flush = 1'b1; wr_en = 1'b1; wr_data = 8'h99;
        tick();
        flush = 1'b0; wr_en = 1'b0;
        check_eq("flush_count", 32'(count0), 32'd0);
        check_eq("flush_empty", 32'(empty0), 32'd1);
        check_eq("flush_rd_valid", 32'(rd_valid0), 32'd0);
        check_eq("flush_ovf", 32'(ovf0), 32'd0);
        check_eq("flush_udf", 32'(udf0), 32'd0);
        tick();
        check_eq("flush_write_dropped", 32'(count0), 32'd0);
        push(8'h77);
        pop_expect("post_flush", 8'h77);

        // Asynchronous reset mid-burst at count=4
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = DW'(8'h41 + i);
            tick();
        end
        check_eq("burst_count", 32'(count0), 32'd4);
        #2;
        reset = 1'b1;
        wr_en = 1'b0;
        #1;
        check_eq("async_rst_count", 32'(count0), 32'd0);
        check_eq("async_rst_empty", 32'(empty0), 32'd1);
        check_eq("async_rst_aempty", 32'(aempty0), 32'd1);
        check_eq("async_rst_afull", 32'(afull0), 32'd0);
        check_eq("async_rst_rd_data", 32'(rd_data0), 32'd0);
        check_eq("async_rst_fwft_valid", 32'(rd_valid1), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        wr_en = 1'b1; wr_data = 8'h55;
        tick();
        wr_en = 1'b0;
        check_eq("post_rst_count", 32'(count0), 32'd1);
        pop_expect("post_rst_pop", 8'h55);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
